// File: rtl/collatz_pkg.sv
// Shared types and helpers for the Collatz engine.
package collatz_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  typedef struct packed {
    logic ovf;
    logic tmo;
    logic zro;
  } status_t;

  // Largest step limit that still leaves headroom for a +2 increment.
  function automatic int unsigned max_steps_for(input int unsigned kw);
    return (32'd1 << kw) - 32'd2;
  endfunction

endpackage

// File: rtl/collatz_if.sv
// Start/result bundle of the Collatz engine; the peak signal exists only with COLLATZ_PEAK_EN.
interface collatz_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned KW    = 20
);
  logic             st;
  logic [WIDTH-1:0] co;
  logic [WIDTH-1:0] x;
  logic [KW-1:0]    k;
  logic             bs;
  logic             done;
  logic             ovf;
  logic             tmo;
  logic             zro;
`ifdef COLLATZ_PEAK_EN
  logic [WIDTH-1:0] peak;

  modport master (output st, co, input x, k, bs, done, ovf, tmo, zro, peak);
  modport slave  (input st, co, output x, k, bs, done, ovf, tmo, zro, peak);
`else
  modport master (output st, co, input x, k, bs, done, ovf, tmo, zro);
  modport slave  (input st, co, output x, k, bs, done, ovf, tmo, zro);
`endif
endinterface

// File: rtl/collatz_step.sv
// One combinational Collatz step: next value, step increment and overflow flag.
module collatz_step #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SHORTCUT = 0
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] x_o,
  output logic [1:0]       inc_o,
  output logic             ovf_o
);

  logic [WIDTH+1:0] t3;
  logic [WIDTH+1:0] t;

  always_comb begin
    // 3x+1 needs two extra bits so overflow can be seen rather than wrapped.
    t3 = {2'b00, x_i} + {1'b0, x_i, 1'b0} + (WIDTH+2)'(1);
    t  = (SHORTCUT != 0) ? (t3 >> 1) : t3;
    if (!x_i[0]) begin
      x_o   = x_i >> 1;
      inc_o = 2'd1;
      ovf_o = 1'b0;
    end else begin
      x_o   = t[WIDTH-1:0];
      inc_o = (SHORTCUT != 0) ? 2'd2 : 2'd1;
      ovf_o = |t[WIDTH+1:WIDTH];
    end
  end

endmodule

// File: rtl/collatz_engine.sv
// Collatz sequence engine: iterates one step per cycle from a seed until 1, zero, overflow or
// step limit. Define COLLATZ_PEAK_EN to add the running-maximum register and peak output.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned KW        = 20,
  parameter int unsigned MAX_STEPS = max_steps_for(KW),
  parameter int unsigned SHORTCUT  = 0
) (
  input logic      clk,
  input logic      rst_n,
  collatz_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [KW-1:0]    k_q, k_d;
  status_t          stat_q, stat_d;
  logic             upd;

  logic [WIDTH-1:0] step_x;
  logic [1:0]       step_inc;
  logic             step_ovf;
  logic             at_limit;

  collatz_step #(
    .WIDTH    (WIDTH),
    .SHORTCUT (SHORTCUT)
  ) u_step (
    .x_i   (x_q),
    .x_o   (step_x),
    .inc_o (step_inc),
    .ovf_o (step_ovf)
  );

  assign at_limit = (k_q >= KW'(MAX_STEPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    k_d     = k_q;
    stat_d  = stat_q;
    upd     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.st) begin
          state_d = StRun;
          x_d     = bus.co;
          k_d     = '0;
          stat_d  = '0;
        end
      end
      StRun: begin
        if (x_q == '0) begin
          stat_d.zro = 1'b1;
          state_d    = StFin;
        end else if (x_q == WIDTH'(1)) begin
          state_d = StFin;
        end else if (at_limit) begin
          stat_d.tmo = 1'b1;
          state_d    = StFin;
        end else if (step_ovf) begin
          // Overflowing step is abandoned: x and k keep their last valid values.
          stat_d.ovf = 1'b1;
          state_d    = StFin;
        end else begin
          x_d = step_x;
          k_d = k_q + KW'(step_inc);
          upd = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      k_q    <= '0;
      stat_q <= '0;
    end else begin
      x_q    <= x_d;
      k_q    <= k_d;
      stat_q <= stat_d;
    end
  end

`ifdef COLLATZ_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (state_q == StIdle && bus.st) peak_d = bus.co;
    else if (upd && (step_x > peak_q)) peak_d = step_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign bus.peak = peak_q;
`endif

  always_comb begin
    bus.bs   = (state_q != StIdle);
    bus.done = (state_q == StFin);
    bus.x    = x_q;
    bus.k    = k_q;
    bus.ovf  = stat_q.ovf;
    bus.tmo  = stat_q.tmo;
    bus.zro  = stat_q.zro;
  end

endmodule
